// File: rtl/control_unit_pkg.sv
// control_unit_pkg
// Shared definitions for the 8-bit microcontroller datapath: sequencer
// state encoding, instruction opcodes, accumulator source selects and ALU
// operation codes. Imported by control_unit, the accumulator and the ALU.
package control_unit_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

  // Opcodes (ir[7:4]); operand is ir[3:0]
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_MOVA = 4'h7;
  localparam logic [3:0] OP_MOVR = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_JC   = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_MOVI = 4'hC;
  localparam logic [3:0] OP_RSV0 = 4'hD;
  localparam logic [3:0] OP_RSV1 = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Accumulator source selects
  localparam logic [1:0] ACC_ALU = 2'b00;
  localparam logic [1:0] ACC_REG = 2'b10;
  localparam logic [1:0] ACC_IMM = 2'b11;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOT = 3'b101;

endpackage

// File: rtl/control_unit_decode.sv
// control_decode
// Purely combinational instruction decoder. Turns the registered opcode
// plus the ALU flags into the one-cycle EXEC strobe set, a jump-taken flag
// and a halt request. All outputs are forced inactive unless exec is high,
// so the strobes only ever depend on sequencer state and ir registers.
// Ports:
//   exec       - sequencer is in EXEC
//   opcode     - ir[7:4]
//   zflag      - ALU zero flag
//   cflag      - ALU carry flag
//   selacc     - accumulator source select
//   loadacc    - accumulator load strobe
//   aluop      - ALU operation code
//   loadflags  - flag register update strobe
//   loadreg    - register-file write strobe
//   jump_taken - pc must load the in-page jump target
//   halt_req   - sequencer must enter HALT
module control_decode
  import control_unit_pkg::*;
(
  input  logic       exec,
  input  logic [3:0] opcode,
  input  logic       zflag,
  input  logic       cflag,
  output logic [1:0] selacc,
  output logic       loadacc,
  output logic [2:0] aluop,
  output logic       loadflags,
  output logic       loadreg,
  output logic       jump_taken,
  output logic       halt_req
);

  // Opcode decode; everything defaults to the idle value
  always_comb begin
    selacc     = ACC_ALU;
    loadacc    = 1'b0;
    aluop      = ALU_ADD;
    loadflags  = 1'b0;
    loadreg    = 1'b0;
    jump_taken = 1'b0;
    halt_req   = 1'b0;
    if (exec) begin
      case (opcode)
        OP_ADD:  begin aluop = ALU_ADD; loadacc = 1'b1; loadflags = 1'b1; end
        OP_SUB:  begin aluop = ALU_SUB; loadacc = 1'b1; loadflags = 1'b1; end
        OP_AND:  begin aluop = ALU_AND; loadacc = 1'b1; loadflags = 1'b1; end
        OP_OR:   begin aluop = ALU_OR;  loadacc = 1'b1; loadflags = 1'b1; end
        OP_XOR:  begin aluop = ALU_XOR; loadacc = 1'b1; loadflags = 1'b1; end
        OP_NOT:  begin aluop = ALU_NOT; loadacc = 1'b1; loadflags = 1'b1; end
        OP_MOVA: begin selacc = ACC_REG; loadacc = 1'b1; end
        OP_MOVR: loadreg = 1'b1;
        OP_JZ:   jump_taken = zflag;
        OP_JC:   jump_taken = cflag;
        OP_JMP:  jump_taken = 1'b1;
        OP_MOVI: begin selacc = ACC_IMM; loadacc = 1'b1; end
        OP_HALT: halt_req = 1'b1;
        // NOP and the two reserved opcodes issue nothing
        default: halt_req = 1'b0;
      endcase
    end else begin
      loadacc = 1'b0;
    end
  end

endmodule

// File: rtl/control_unit.sv
// control_unit
// Instruction sequencer for the 8-bit microcontroller. Fetches one
// instruction per step into ir, spends exactly one EXEC cycle issuing the
// decoded strobes, then advances or jumps the program counter.
// Ports:
//   clk       - system clock, rising edge
//   clr       - asynchronous active-high reset
//   run       - step enable, sampled in FETCH only
//   instr     - program memory data at address pc
//   zflag     - ALU zero flag, used by JZ during EXEC
//   cflag     - ALU carry flag, used by JC during EXEC
//   pc        - current instruction address
//   selacc    - accumulator source (00 ALU, 10 reg, 11 imm)
//   loadacc   - accumulator load strobe
//   imm       - immediate operand, ir[3:0]
//   aluop     - ALU operation code
//   loadflags - flag register update strobe
//   regaddr   - register-file address, ir[3:0]
//   loadreg   - register-file write strobe
//   halted    - high while in HALT
module control_unit
  import control_unit_pkg::*;
#(
  parameter int unsigned           PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                run,
  input  logic [7:0]          instr,
  input  logic                zflag,
  input  logic                cflag,
  output logic [PC_WIDTH-1:0] pc,
  output logic [1:0]          selacc,
  output logic                loadacc,
  output logic [3:0]          imm,
  output logic [2:0]          aluop,
  output logic                loadflags,
  output logic [3:0]          regaddr,
  output logic                loadreg,
  output logic                halted
);

  state_t              state_r;
  logic [7:0]          ir_r;
  logic [PC_WIDTH-1:0] pc_r;
  logic                halted_r;

  logic                exec_s;
  logic                jump_taken_s;
  logic                halt_req_s;
  logic [PC_WIDTH-1:0] jump_pc_s;
  logic [PC_WIDTH-1:0] inc_pc_s;

  assign exec_s = (state_r == ST_EXEC);

  // Jumps stay inside the current 16-instruction page; masking instead of
  // slicing keeps this legal for PC_WIDTH == 4.
  assign jump_pc_s = (pc_r & ~PC_WIDTH'(4'hF)) | PC_WIDTH'(ir_r[3:0]);
  assign inc_pc_s  = pc_r + PC_WIDTH'(1'b1);

  control_decode u_decode (
    .exec       (exec_s),
    .opcode     (ir_r[7:4]),
    .zflag      (zflag),
    .cflag      (cflag),
    .selacc     (selacc),
    .loadacc    (loadacc),
    .aluop      (aluop),
    .loadflags  (loadflags),
    .loadreg    (loadreg),
    .jump_taken (jump_taken_s),
    .halt_req   (halt_req_s)
  );

  // Sequencer FSM with instruction register and program counter
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r  <= ST_FETCH;
      ir_r     <= 8'h00;
      pc_r     <= RESET_PC;
      halted_r <= 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (run) begin
            ir_r    <= instr;
            state_r <= ST_EXEC;
          end else begin
            state_r <= ST_FETCH;
          end
        end
        ST_EXEC: begin
          if (halt_req_s) begin
            state_r  <= ST_HALT;
            halted_r <= 1'b1;
          end else if (jump_taken_s) begin
            pc_r    <= jump_pc_s;
            state_r <= ST_FETCH;
          end else begin
            pc_r    <= inc_pc_s;
            state_r <= ST_FETCH;
          end
        end
        // Only clr leaves HALT
        ST_HALT: begin
          state_r  <= ST_HALT;
          halted_r <= 1'b1;
        end
        default: begin
          state_r  <= ST_FETCH;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

  assign pc      = pc_r;
  assign imm     = ir_r[3:0];
  assign regaddr = ir_r[3:0];
  assign halted  = halted_r;

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Instruction sequencer/decoder for the 8-bit microcontroller; drives the accumulator's load controls (selacc, loadacc, imm) plus ALU, flag and register-file strobes.
- Fetches one 8-bit instruction per step from program memory, holds it in an instruction register, and issues a single one-cycle EXEC strobe set.
- Owns the program counter and conditional/unconditional jumps on ALU zero/carry flags.

Parameters:
- PC_WIDTH, 8, program-counter/address width (min 4).
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  system clock, all state on rising edge.
- clr  in  1  reset: asynchronous, active-high; returns block to reset state immediately.
- run  in  1  step enable; FETCH advances only when high.
- instr  in  8  program-memory data at address pc; opcode [7:4], operand [3:0].
- zflag  in  1  ALU zero flag (registered in ALU/flag reg).
- cflag  in  1  ALU carry flag.
- pc  out  PC_WIDTH  current instruction address.
- selacc  out  2  accumulator source: 00 ALU, 10 register, 11 immediate.
- loadacc  out  1  accumulator load strobe.
- imm  out  4  immediate operand (= ir[3:0]).
- aluop  out  3  ALU operation code.
- loadflags  out  1  flag-register update strobe.
- regaddr  out  4  register-file address (= ir[3:0]).
- loadreg  out  1  register-file write strobe (data = accumulator).
- halted  out  1  high while in HALT state.

Behaviour:
- States: FETCH, EXEC, HALT. Reset: state=FETCH, pc=RESET_PC, ir=8'h00; all strobes 0, selacc=00, aluop=000, halted=0.
- FETCH: if run=1, ir<=instr, go EXEC; else hold (pc, ir unchanged). No strobes asserted in FETCH.
- EXEC (exactly one cycle): strobes decoded combinationally from ir; consumers sample at the closing edge. Then pc updates and state returns to FETCH (or HALT). Throughput: 2 cycles/instruction with run held high.
- Opcodes (operand n = ir[3:0]):
  0000 NOP: no strobes.
  0001 ADD / 0010 SUB / 0011 AND / 0100 OR / 0101 XOR Rn: aluop=000/001/010/011/100, regaddr=n, selacc=00, loadacc=1, loadflags=1.
  0110 NOT: aluop=101, selacc=00, loadacc=1, loadflags=1; operand ignored.
  0111 MOVA Rn: selacc=10, regaddr=n, loadacc=1.
  1000 MOVR Rn: regaddr=n, loadreg=1.
  1001 JZ k: if zflag=1 jump. 1010 JC k: if cflag=1 jump. 1011 JMP k: always jump.
  1100 MOVI k: selacc=11, imm=k, loadacc=1 (accumulator loads {4'b0,k}).
  1101, 1110: reserved, executed as NOP.
  1111 HALT: no strobes; go HALT.
- PC update at end of EXEC: jump taken -> pc <= {pc[PC_WIDTH-1:4], k} (same 16-instruction page); otherwise pc <= pc+1 modulo 2^PC_WIDTH (all-ones wraps to 0). HALT: pc not incremented.
- Flags sampled during EXEC only; flag changes in FETCH are irrelevant.
- HALT: halted=1, no strobes, run ignored; exit only via clr.
- clr asserted mid-EXEC: strobes drop asynchronously with state; no partial pc update.
- run deasserted during EXEC: no effect; EXEC completes, block then waits in FETCH.
- Strobes must be glitch-free from state/ir register outputs only (no dependency on instr).

Decomposition:
- Shared package: opcode constants, state encoding, selacc encodings (ACC_ALU=00, ACC_REG=10, ACC_IMM=11), aluop codes; shared with accumulator and ALU.
- One sub-module: control_decode (combinational ir + flags -> strobes, jump_taken, halt request); control_unit holds FSM, ir, pc.

Test Plan:
- Reset then program MOVI 5 (8'hC5), run=1 -> EXEC in cycle 2: selacc=11, imm=4'h5, loadacc=1; pc 0->1.
- ADD R3 (8'h13) -> aluop=000, regaddr=3, selacc=00, loadacc=1, loadflags=1; MOVR R2 (8'h82) -> loadreg=1, regaddr=2, loadacc=0.
- pc=8'h23, JZ 9 (8'h99): zflag=1 -> pc=8'h29; zflag=0 -> pc=8'h24; JMP F at pc=8'hFF -> pc=8'hFF; NOP at 8'hFF -> pc=8'h00.
- run=0 for 5 cycles in FETCH -> pc, ir, strobes constant; run=1 resumes with instr sampled on that edge.
- HALT (8'hF0) -> halted=1, pc unchanged, no strobes for 10 cycles despite run=1; clr pulse -> pc=0, halted=0.
- clr asserted mid-EXEC of MOVI -> loadacc falls without a clock edge; after release, FETCH at pc=RESET_PC.
